// File: rtl/db_pkg.sv
// rtl/db_pkg.sv - shared state encoding and sizing helper for the button debouncer
package db_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } db_state_t;

    // Bits needed to hold values 0..max_count inclusive.
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/db_channel.sv
// rtl/db_channel.sv - one button: synchroniser, bounce filter FSM, strobes, optional auto-repeat (HOLD_REPEAT_EN)
module db_channel
    import db_pkg::*;
#(
    parameter int DB_CYCLES   = 100000,
    parameter int SYNC_STAGES = 2
`ifdef HOLD_REPEAT_EN
    ,
    parameter int REPEAT_DELAY  = 50000000,
    parameter int REPEAT_PERIOD = 10000000
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rel
);

    localparam int CW = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    db_state_t              state;
    logic [CW-1:0]          cnt;
    logic                   rpt_fire;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw};
        end
    end

    assign s = sync[SYNC_STAGES-1];

`ifdef HOLD_REPEAT_EN
    localparam int RW = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
    localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rpt_cnt;
    logic          rpt_periodic;

    assign rpt_fire = (state == PRESSED) && s &&
                      (rpt_cnt == (rpt_periodic ? PER_LAST : DLY_LAST));

    // Any cycle not spent holding in PRESSED restarts the initial delay.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rpt_cnt      <= '0;
            rpt_periodic <= 1'b0;
        end else if (state != PRESSED || !s) begin
            rpt_cnt      <= '0;
            rpt_periodic <= 1'b0;
        end else if (rpt_fire) begin
            rpt_cnt      <= '0;
            rpt_periodic <= 1'b1;
        end else begin
            rpt_cnt <= rpt_cnt + 1'b1;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RELEASED;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            press <= 1'b0;
            rel   <= 1'b0;
            case (state)
                RELEASED: begin
                    if (s) begin
                        state <= PRESS_WAIT;
                        cnt   <= CW'(1);
                    end
                end
                PRESS_WAIT: begin
                    if (!s) begin
                        state <= RELEASED;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= PRESSED;
                        cnt   <= '0;
                        level <= 1'b1;
                        press <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!s) begin
                        state <= RELEASE_WAIT;
                        cnt   <= CW'(1);
                    end else if (rpt_fire) begin
                        press <= 1'b1;
                    end
                end
                RELEASE_WAIT: begin
                    if (s) begin
                        state <= PRESSED;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= RELEASED;
                        cnt   <= '0;
                        level <= 1'b0;
                        rel   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= RELEASED;
                    cnt   <= '0;
                    level <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/btn_debounce_multi.sv
// rtl/btn_debounce_multi.sv - N independent debounced button channels; auto-repeat under HOLD_REPEAT_EN
module btn_debounce_multi
    import db_pkg::*;
#(
    parameter int CHANNELS      = 4,
    parameter int DB_CYCLES     = 100000,
    parameter int SYNC_STAGES   = 2,
    parameter int REPEAT_DELAY  = 50000000,
    parameter int REPEAT_PERIOD = 10000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] btn_raw,
    output logic [CHANNELS-1:0] btn_level,
    output logic [CHANNELS-1:0] btn_press,
    output logic [CHANNELS-1:0] btn_release
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        db_channel #(
            .DB_CYCLES    (DB_CYCLES),
            .SYNC_STAGES  (SYNC_STAGES)
`ifdef HOLD_REPEAT_EN
            ,
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
`endif
        ) u_ch (
            .clk  (clk),
            .reset(reset),
            .raw  (btn_raw[i]),
            .level(btn_level[i]),
            .press(btn_press[i]),
            .rel  (btn_release[i])
        );
    end

`ifndef HOLD_REPEAT_EN
    // Repeat timing only shapes the auto-repeat build; nothing is generated here.
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_repeat_unused
    end
`endif

endmodule

// File: tb/tb_btn_debounce_multi.sv
// tb/tb_btn_debounce_multi.sv - randomized and directed bench for btn_debounce_multi against a run-length model
module tb_btn_debounce_multi;

    localparam int CH   = 4;
    localparam int DB   = 4;
    localparam int SYNC = 2;
    localparam int RD   = 10;
    localparam int RP   = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [CH-1:0] btn_raw = '0;
    logic [CH-1:0] btn_level, btn_press, btn_release;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: raw delay line, accepted level, run of disagreeing samples, cycles held
    logic [CH-1:0] pipe [SYNC];
    logic [CH-1:0] exp_level, exp_press, exp_rel;
    int            run  [CH];
    int            held [CH];

    btn_debounce_multi #(
        .CHANNELS     (CH),
        .DB_CYCLES    (DB),
        .SYNC_STAGES  (SYNC),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < SYNC; k++) pipe[k] = '0;
        exp_level = '0;
        exp_press = '0;
        exp_rel   = '0;
        for (int c = 0; c < CH; c++) begin
            run[c]  = 0;
            held[c] = 0;
        end
    endtask

    task automatic model_step(input logic [CH-1:0] raw);
        logic [CH-1:0] s;
        s = pipe[SYNC-1];
        for (int k = SYNC - 1; k > 0; k--) pipe[k] = pipe[k-1];
        pipe[0] = raw;
        exp_press = '0;
        exp_rel   = '0;
        for (int c = 0; c < CH; c++) begin
            if (s[c] != exp_level[c]) begin
                run[c]++;
                held[c] = 0;
                if (run[c] == DB) begin
                    exp_level[c] = s[c];
                    run[c] = 0;
                    if (s[c]) exp_press[c] = 1'b1;
                    else      exp_rel[c]   = 1'b1;
                end
            end else begin
`ifdef HOLD_REPEAT_EN
                if (exp_level[c] && run[c] == 0) begin
                    held[c]++;
                    if (held[c] == RD || (held[c] > RD && (held[c] - RD) % RP == 0))
                        exp_press[c] = 1'b1;
                end
`endif
                run[c] = 0;
            end
        end
    endtask

    task automatic step(input logic [CH-1:0] raw);
        btn_raw = raw;
        model_step(raw);
        @(posedge clk);
        @(negedge clk);
        check("level",   btn_level,   exp_level);
        check("press",   btn_press,   exp_press);
        check("release", btn_release, exp_rel);
        check("excl",    btn_press & btn_release, 0);
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        #1;
        check("rst_level",   btn_level,   0);
        check("rst_press",   btn_press,   0);
        check("rst_release", btn_release, 0);
        model_reset();
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int rise;
        int pulses;
        int found;
        logic [CH-1:0] cur;

        model_reset();
        @(negedge clk);
        do_reset(3);

        // Clean press on channel 0
        rise = -1;
        for (int k = 1; k <= 20; k++) begin
            step(4'b0001);
            if (rise < 0 && btn_level[0]) rise = k - 1;
        end
        check("lat_press0", rise, SYNC + DB - 1);

        // Bounce on channel 1, then stable
        pulses = 0;
        rise = -1;
        for (int k = 1; k <= 20; k++) begin
            logic b;
            b = (k > 8) ? 1'b1 : (((k - 1) / 2) % 2 == 0);
            step({2'b00, b, 1'b1});
            if (btn_press[1]) begin
                pulses++;
                if (rise < 0) rise = k - 9;
            end
        end
        check("bounce_pulses1", pulses, 1);
        check("lat_bounce1", rise, SYNC + DB - 1);

        // Release on channel 0 with a short 1-glitch first
        pulses = 0;
        rise = -1;
        for (int k = 1; k <= 18; k++) begin
            logic b;
            b = (k == 3 || k == 4);
            step({2'b00, 1'b1, b});
            if (btn_release[0]) begin
                pulses++;
                if (rise < 0) rise = k - 5;
            end
        end
        check("release_pulses0", pulses, 1);
        check("lat_release0", rise, SYNC + DB - 1);

        // All channels together
        for (int k = 0; k < 12; k++) step(4'b0000);
        found = 0;
        for (int k = 0; k < 12; k++) begin
            step(4'b1111);
            if (btn_press == 4'hF) found++;
        end
        check("simul_press", found, 1);

        // Reset with channel 3 pressed and channel 2 mid-qualification
        for (int k = 0; k < 12; k++) step(4'b1000);
        for (int k = 0; k < 4; k++) step(4'b1100);
        check("pre_rst_level", btn_level, 4'b1000);
        btn_raw = 4'b1000;
        do_reset(2);
        rise = -1;
        pulses = 0;
        for (int k = 1; k <= 12; k++) begin
            step(4'b1000);
            if (btn_press[3]) begin
                pulses++;
                if (rise < 0) rise = k - 1;
            end
        end
        check("post_rst_press3", rise, SYNC + DB - 1);
        check("post_rst_pulses3", pulses, 1);

        // Long hold on channel 0
        for (int k = 0; k < 12; k++) step(4'b0000);
        pulses = 0;
        for (int k = 0; k < 30; k++) begin
            step(4'b0001);
            if (btn_press[0]) pulses++;
        end
`ifdef HOLD_REPEAT_EN
        check("hold_pulses0", pulses, 6);
`else
        check("hold_pulses0", pulses, 1);
`endif
        for (int k = 0; k < 12; k++) step(4'b0000);

        // Random bouncing traffic
        cur = '0;
        for (int k = 0; k < 800; k++) begin
            for (int c = 0; c < CH; c++)
                if ($urandom_range(0, 5) == 0) cur[c] = ~cur[c];
            step(cur);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/btn_debounce_multi.md
Name: btn_debounce_multi

Overview:
Parametrised N-channel push-button conditioner for the board inputs (pause, ADJ, SEL buttons) feeding top_fsm.
Per channel: metastability synchroniser, bounce filter with a cycle-exact stability window, and debounced level plus one-cycle press/release strobes.
Replaces ad-hoc single-button debounce logic; all game-control buttons pass through one instance.

Parameters:
CHANNELS, 4, number of independent button inputs (>=1)
DB_CYCLES, 100000, consecutive stable synchronised samples needed to accept a change (>=2); 1 ms at 100 MHz
SYNC_STAGES, 2, flip-flops in the input synchroniser (>=2)
REPEAT_DELAY, 50000000, cycles held before the first auto-repeat strobe (optional feature only)
REPEAT_PERIOD, 10000000, cycles between later auto-repeat strobes (optional feature only)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
btn_raw  input  CHANNELS  raw, asynchronous, bouncing button levels (1 = pressed)
btn_level  output  CHANNELS  debounced level per channel
btn_press  output  CHANNELS  one-cycle strobe on accepted press (and on auto-repeat when enabled)
btn_release  output  CHANNELS  one-cycle strobe on accepted release

Behaviour:
- Reset (async assert, sync release): synchroniser FFs, counters and strobes to 0; every channel to RELEASED; btn_level = 0.
- Channels fully independent; s[i] = output of the last synchroniser stage.
- FSM per channel:
  - RELEASED: level 0. If s=1: go PRESS_WAIT, cnt=1.
  - PRESS_WAIT: s=0 returns to RELEASED, cnt=0 (bounce rejected, no strobe). s=1 with cnt<DB_CYCLES-1 increments cnt. s=1 with cnt=DB_CYCLES-1 goes PRESSED, level=1, btn_press=1 for that one cycle.
  - PRESSED: level 1. If s=0: go RELEASE_WAIT, cnt=1.
  - RELEASE_WAIT: mirror of PRESS_WAIT. s=1 returns to PRESSED, no strobe. DB_CYCLES consecutive s=0 samples give RELEASED, level=0, btn_release pulse.
- Latency: a clean edge on btn_raw reaches btn_level/strobe SYNC_STAGES+DB_CYCLES-1 clocks after the first clk edge that samples it.
- Any glitch shorter than DB_CYCLES synchronised samples never changes btn_level and never produces a strobe.
- btn_press and btn_release are never both 1 on one channel in the same cycle. Strobes are exactly one cycle wide and registered.
- Counter width is $clog2(DB_CYCLES+1). The counter saturates and never wraps.
- Reset mid-count or mid-press: the channel returns to RELEASED immediately with no strobe. A button still held after reset release must re-qualify for a full DB_CYCLES window, then emits btn_press.

Optional Feature:
HOLD_REPEAT_EN
- Defined: in PRESSED, a repeat counter runs. btn_press pulses after REPEAT_DELAY cycles in PRESSED, then every REPEAT_PERIOD cycles while the channel stays PRESSED. Leaving PRESSED (including entering RELEASE_WAIT) clears the repeat counter; a rejected release bounce restarts the delay.
- Undefined: no repeat counter is built. btn_press fires only on the accepted press; REPEAT_* parameters are ignored.

Decomposition:
- Package db_pkg: state enum (RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT), 2-bit encoding, and a helper constant function for the counter width.
- Sub-module db_channel: synchroniser, FSM, counters and optional repeat for one bit. Top level generates CHANNELS instances.

Test Plan:
All tests use CHANNELS=4, DB_CYCLES=4, SYNC_STAGES=2, REPEAT_DELAY=10, REPEAT_PERIOD=3.
1. Clean press: btn_raw[0] 0->1 held 20 cycles -> btn_level[0] rises exactly 5 clocks after the first sampling edge; btn_press[0] high one cycle; other channels stay 0.
2. Bounce: btn_raw[1] toggles 1,0,1,0 at 2-cycle intervals, then held 1 -> no strobe during the bounce; one btn_press[1] 5 clocks after the final stable edge.
3. Release: channel 0 pressed, then btn_raw[0]=0 -> btn_level falls after 5 clocks; one btn_release[0] pulse; a 2-cycle 1-glitch before that produces no strobe.
4. Simultaneous: all 4 raw inputs rise on the same edge -> all btn_press bits pulse on the same cycle.
5. Reset mid-operation: assert reset while channel 2 is in PRESS_WAIT and channel 3 is PRESSED -> all outputs 0 asynchronously; channel 3 still held after release -> btn_press[3] after a full window.
6. HOLD_REPEAT_EN defined, hold channel 0 for 30 cycles -> btn_press[0] at acceptance, again 10 cycles later, then every 3 cycles. Undefined -> a single pulse only.
